kcell_ctrl: RTL and testbench

KCELL_CTRL -- requirements
Module: kcell_ctrl

---
 rtl/kcell_ctrl.sv | 97 +++++++++
 tb/tb_kcell_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/kcell_ctrl.sv
// kcell_ctrl: sequences weight load, activation streaming and result collection for a DIMX x DIMY kernel cell
module kcell_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int OUT_DATA_WIDTH = 32,
  parameter int DIMX           = 3,
  parameter int DIMY           = 3,
  parameter int NUM_CELLS      = DIMX*DIMY,
  parameter int RES_LAT        = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [NUM_CELLS*DATA_WIDTH-1:0] cfg_wgt,
  input  logic [15:0]                     cfg_ncols,
  input  logic                            act_in_valid,
  output logic                            act_in_ready,
  input  logic [DIMY*DATA_WIDTH-1:0]      act_in_data,
  output logic [NUM_CELLS*DATA_WIDTH-1:0] wgt_data,
  output logic [NUM_CELLS-1:0]            wgt_load_gbl,
  output logic [DIMY*DATA_WIDTH-1:0]      act_data,
  output logic [OUT_DATA_WIDTH-1:0]       result_in,
  input  logic [OUT_DATA_WIDTH-1:0]       result,
  output logic                            out_valid,
  output logic [OUT_DATA_WIDTH-1:0]       out_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, STREAM = 3'd2, DRAIN = 3'd3, FIN = 3'd4;
  logic [2:0]         state;
  logic [15:0]        cnt, beats, ncols;
  logic               started;
  logic [RES_LAT-1:0] tags;
  logic               accept, last, tag_ok, cfg_ok;
  assign busy         = state != IDLE;
  assign cfg_ready    = reset && state == IDLE;
  assign act_in_ready = state == STREAM;
  assign accept       = act_in_valid && act_in_ready;
  assign last         = beats + 16'd1 == ncols;
  assign tag_ok       = beats + 16'd1 >= 16'(DIMX);
  assign cfg_ok       = cfg_ncols >= 16'(DIMX);
  assign result_in    = '0;
  assign wgt_load_gbl = state == LOAD ? NUM_CELLS'(1) << cnt : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      beats     <= '0;
      ncols     <= '0;
      started   <= 1'b0;
      tags      <= '0;
      wgt_data  <= '0;
      act_data  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      act_data  <= '0;
      tags      <= (tags << 1) | RES_LAT'(accept && tag_ok);
      out_valid <= tags[RES_LAT-1];
      if (tags[RES_LAT-1]) out_data <= result;
      // registered so the completion pulse lands after the final result
      done      <= state == FIN;
      case (state)
        IDLE: if (cfg_valid) begin
          wgt_data <= cfg_wgt;
          ncols    <= cfg_ncols;
          err      <= !cfg_ok;
          cnt      <= '0;
          beats    <= '0;
          started  <= 1'b0;
          state    <= cfg_ok ? LOAD : FIN;
        end
        LOAD: begin
          cnt <= cnt == 16'(NUM_CELLS-1) ? '0 : cnt + 16'd1;
          if (cnt == 16'(NUM_CELLS-1)) state <= STREAM;
        end
        STREAM: if (accept) begin
          act_data <= act_in_data;
          beats    <= beats + 16'd1;
          started  <= 1'b1;
          if (last) state <= DRAIN;
        end else if (started) begin
          err   <= 1'b1;
          state <= DRAIN;
        end
        DRAIN: begin
          cnt <= cnt + 16'd1;
          if (cnt == 16'(RES_LAT-1)) state <= FIN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kcell_ctrl.sv
// tb_kcell_ctrl: scoreboard bench for kcell_ctrl with a two-stage kernel-cell result model
module tb_kcell_ctrl;
  localparam int DW = 8, OW = 32, NC = 9, RL = 3;
  logic          clk = 0, reset = 0;
  logic          cfg_valid = 0, cfg_ready;
  logic [NC*DW-1:0] cfg_wgt = '0, wgt_data;
  logic [15:0]   cfg_ncols = '0;
  logic          act_in_valid = 0, act_in_ready;
  logic [3*DW-1:0] act_in_data = '0, act_data;
  logic [NC-1:0] wgt_load_gbl;
  logic [OW-1:0] result_in, result, out_data, p1, p2;
  logic          out_valid, busy, done, err;
  typedef struct {logic [OW-1:0] data; int due;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, ov_cnt = 0, done_cnt = 0, load_seen = 0;
  kcell_ctrl dut (.clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_wgt(cfg_wgt), .cfg_ncols(cfg_ncols), .act_in_valid(act_in_valid),
    .act_in_ready(act_in_ready), .act_in_data(act_in_data), .wgt_data(wgt_data),
    .wgt_load_gbl(wgt_load_gbl), .act_data(act_data), .result_in(result_in),
    .result(result), .out_valid(out_valid), .out_data(out_data), .busy(busy),
    .done(done), .err(err));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    p1 <= {8'h5A, act_data};
    p2 <= p1;
  end
  assign result = p2;
  always @(negedge clk) begin
    if (wgt_load_gbl != '0) load_seen++;
    if (done) done_cnt++;
    if (out_valid) begin
      ov_cnt++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected got=%h at cyc %0d, none expected", out_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (out_data !== e.data || cyc != e.due) begin
          fails++;
          $display("FAIL out_data got=%h@%0d exp=%h@%0d", out_data, cyc, e.data, e.due);
        end
      end
    end
  end
  task automatic clear_counts();
    ov_cnt = 0; done_cnt = 0; load_seen = 0;
  endtask
  task automatic send_cfg(input logic [15:0] n, input logic [NC*DW-1:0] w);
    tests++;
    if (cfg_ready !== 1'b1) begin fails++; $display("FAIL cfg_ready got=%b exp=1", cfg_ready); end
    cfg_valid = 1; cfg_ncols = n; cfg_wgt = w;
    @(negedge clk);
    cfg_valid = 0;
  endtask
  task automatic drive_beats(input int n);
    for (int i = 1; i <= n; i++) begin
      act_in_valid = 1;
      act_in_data = 24'($urandom);
      tests++;
      if (act_in_ready !== 1'b1) begin fails++; $display("FAIL act_in_ready beat %0d got=%b exp=1", i, act_in_ready); end
      if (i >= 3) q.push_back('{{8'h5A, act_in_data}, cyc + 1 + RL});
      @(negedge clk);
    end
    act_in_valid = 0;
  endtask
  task automatic wait_done(input int exp_cyc);
    for (int t = 0; t < 30 && !done; t++) @(negedge clk);
    tests++;
    if (!done) begin fails++; $display("FAIL done_timeout got=0 exp=1"); end
    else if (cyc != exp_cyc) begin fails++; $display("FAIL done_cycle got=%0d exp=%0d", cyc, exp_cyc); end
    @(negedge clk);
  endtask
  task automatic check_zero_outputs(input string tag);
    tests++;
    if ({wgt_data, wgt_load_gbl, act_data, out_data, out_valid, done, err, busy, cfg_ready} !== '0) begin
      fails++;
      $display("FAIL %s_outputs got wd=%h gl=%h ad=%h od=%h ov=%b d=%b e=%b b=%b cr=%b exp=all 0", tag,
        wgt_data, wgt_load_gbl, act_data, out_data, out_valid, done, err, busy, cfg_ready);
    end
  endtask
  task automatic run_tile(input logic [15:0] n);
    int r;
    send_cfg(n, 72'hA1B2C3D4E5F6071829);
    repeat (NC) @(negedge clk);
    drive_beats(n);
    r = cyc;
    wait_done(r + 4);
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    send_cfg(16'd5, 72'hFFEEDDCCBBAA998877);
    @(posedge clk); #2 reset = 0;
    #1 check_zero_outputs("reset");
    @(negedge clk); reset = 1;
    @(negedge clk);
    tests++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL reset_release got cr=%b busy=%b exp cr=1 busy=0", cfg_ready, busy); end
  endtask
  task automatic test_load();
    logic [NC*DW-1:0] w = 72'h010203040506070809;
    int r;
    clear_counts();
    send_cfg(16'd5, w);
    for (int k = 0; k < NC; k++) begin
      tests++;
      if (wgt_load_gbl !== NC'(1) << k || wgt_data !== w || busy !== 1'b1) begin
        fails++;
        $display("FAIL load_k%0d got gl=%h wd=%h busy=%b exp gl=%h wd=%h busy=1", k, wgt_load_gbl, wgt_data, busy, NC'(1) << k, w);
      end
      @(negedge clk);
    end
    tests++;
    if (wgt_load_gbl !== '0 || act_in_ready !== 1'b1) begin fails++; $display("FAIL load_end got gl=%h rdy=%b exp gl=0 rdy=1", wgt_load_gbl, act_in_ready); end
    drive_beats(5);
    r = cyc;
    wait_done(r + 4);
    tests++;
    if (wgt_data !== w || load_seen != NC) begin fails++; $display("FAIL load_hold got wd=%h loads=%0d exp wd=%h loads=%0d", wgt_data, load_seen, w, NC); end
  endtask
  task automatic test_stream();
    int r;
    clear_counts();
    send_cfg(16'd5, 72'h112233445566778899);
    repeat (NC) @(negedge clk);
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (act_data !== '0 || err !== 1'b0 || act_in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_idle got ad=%h err=%b rdy=%b exp ad=0 err=0 rdy=1", act_data, err, act_in_ready);
      end
    end
    drive_beats(5);
    r = cyc;
    tests++;
    if (act_in_ready !== 1'b0) begin fails++; $display("FAIL stream_ready_after got=%b exp=0", act_in_ready); end
    wait_done(r + 4);
    tests++;
    if (ov_cnt != 3 || done_cnt != 1 || err !== 1'b0 || q.size() != 0) begin
      fails++;
      $display("FAIL stream_totals got ov=%0d done=%0d err=%b q=%0d exp ov=3 done=1 err=0 q=0", ov_cnt, done_cnt, err, q.size());
    end
  endtask
  task automatic test_gap();
    int r;
    clear_counts();
    send_cfg(16'd6, 72'h0F0E0D0C0B0A090807);
    repeat (NC) @(negedge clk);
    drive_beats(3);
    r = cyc;
    @(negedge clk);
    tests++;
    if (err !== 1'b1 || busy !== 1'b1 || act_in_ready !== 1'b0) begin fails++; $display("FAIL gap_err got err=%b busy=%b rdy=%b exp err=1 busy=1 rdy=0", err, busy, act_in_ready); end
    wait_done(r + 5);
    repeat (3) @(negedge clk);
    tests++;
    if (ov_cnt != 1 || done_cnt != 1 || err !== 1'b1 || q.size() != 0) begin
      fails++;
      $display("FAIL gap_totals got ov=%0d done=%0d err=%b q=%0d exp ov=1 done=1 err=1 q=0", ov_cnt, done_cnt, err, q.size());
    end
    send_cfg(16'd3, 72'h0);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL gap_err_clear got=%b exp=0", err); end
    repeat (NC) @(negedge clk);
    drive_beats(3);
    r = cyc;
    wait_done(r + 4);
  endtask
  task automatic test_short();
    int r;
    clear_counts();
    r = cyc;
    send_cfg(16'd2, 72'h123456789ABCDEF012);
    wait_done(r + 2);
    repeat (3) @(negedge clk);
    tests++;
    if (err !== 1'b1 || ov_cnt != 0 || load_seen != 0 || done_cnt != 1 || wgt_data !== 72'h123456789ABCDEF012) begin
      fails++;
      $display("FAIL short_tile got err=%b ov=%0d loads=%0d done=%0d wd=%h exp err=1 ov=0 loads=0 done=1", err, ov_cnt, load_seen, done_cnt, wgt_data);
    end
  endtask
  task automatic test_abort();
    send_cfg(16'd8, 72'h99AA99AA99AA99AA99);
    repeat (NC) @(negedge clk);
    drive_beats(4);
    @(posedge clk); #2 reset = 0;
    #1 check_zero_outputs("abort");
    q.delete();
    clear_counts();
    @(negedge clk); reset = 1;
    repeat (8) @(negedge clk);
    tests++;
    if (ov_cnt != 0 || done_cnt != 0 || busy !== 1'b0) begin fails++; $display("FAIL abort_quiet got ov=%0d done=%0d busy=%b exp 0 0 0", ov_cnt, done_cnt, busy); end
    run_tile(16'd5);
    tests++;
    if (ov_cnt != 3 || done_cnt != 1 || err !== 1'b0 || q.size() != 0) begin
      fails++;
      $display("FAIL abort_rerun got ov=%0d done=%0d err=%b q=%0d exp ov=3 done=1 err=0 q=0", ov_cnt, done_cnt, err, q.size());
    end
  endtask
  task automatic test_back_to_back();
    clear_counts();
    run_tile(16'd7);
    run_tile(16'd3);
    tests++;
    if (ov_cnt != 6 || done_cnt != 2 || q.size() != 0 || result_in !== '0) begin
      fails++;
      $display("FAIL b2b_totals got ov=%0d done=%0d q=%0d ri=%h exp ov=6 done=2 q=0 ri=0", ov_cnt, done_cnt, q.size(), result_in);
    end
  endtask
  initial begin
    test_reset();
    test_load();
    test_stream();
    test_gap();
    test_short();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
